// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one level-strobe register slave among up to four masters.
// Registered strobe forwarding, read-data return pulses, turnaround gap and hold timeout.
module cpu_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter logic [63:0] TIMEOUT     = 64'h100
) (
  input  logic                              iclk,
  input  logic                              irst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] im_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] im_data,
  input  logic [NUM_MASTERS-1:0]            im_wr,
  input  logic [NUM_MASTERS-1:0]            im_rd,
  output logic [NUM_MASTERS-1:0]            om_gnt,
  output logic [NUM_MASTERS-1:0]            om_rvalid,
  output logic [DATA_WIDTH-1:0]             om_rdata,
  output logic [ADDR_WIDTH-1:0]             oaddr,
  output logic [DATA_WIDTH-1:0]             odata,
  output logic                              owr,
  output logic                              ord,
  input  logic [DATA_WIDTH-1:0]             idata,
  output logic                              otimeout,
  output logic [1:0]                        ocur
);

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

  localparam logic [1:0] LastInit = 2'(NUM_MASTERS - 1);
  localparam logic [3:0] GapLast  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_e                  r_state, w_state_nxt;
  logic [1:0]              r_last, w_last_nxt, r_cur, w_cur_nxt;
  logic [NUM_MASTERS-1:0]  r_gnt, w_gnt_nxt, r_rvalid, w_rvalid_nxt, r_mask, w_mask_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_data, w_data_nxt, r_rdata, w_rdata_nxt;
  logic                    r_wr, w_wr_nxt, r_rd, w_rd_nxt, r_timeout, w_timeout_nxt;
  logic [63:0]             r_hold, w_hold_nxt;
  logic [3:0]              r_gap, w_gap_nxt;

  logic [NUM_MASTERS-1:0]  w_req, w_req_m;
  logic [1:0]              w_win, w_idx;
  logic                    w_any;
  int                      w_dist, w_best;
  logic [ADDR_WIDTH-1:0]   w_m_addr;
  logic [DATA_WIDTH-1:0]   w_m_data;
  logic                    w_m_wr, w_m_rd;
  logic                    w_gap_done, w_can_grant, w_hold_exp, w_release, w_to;

  assign w_req   = im_wr | im_rd;
  assign w_req_m = w_req & ~r_mask;

  // Winner is the requester at the smallest distance above the last granted index.
  always_comb begin
    w_win  = '0;
    w_any  = 1'b0;
    w_best = int'(NUM_MASTERS);
    w_dist = 0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      w_dist = (i + 2 * int'(NUM_MASTERS) - int'(r_last) - 1) % int'(NUM_MASTERS);
      if (w_req_m[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = 2'(i);
        w_any  = 1'b1;
      end
    end
  end

  assign w_idx = (r_state == StBusy) ? r_cur : w_win;

  always_comb begin
    w_m_addr = '0;
    w_m_data = '0;
    w_m_wr   = 1'b0;
    w_m_rd   = 1'b0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (2'(i) == w_idx) begin
        w_m_addr = im_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_m_data = im_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_m_wr   = im_wr[i];
        w_m_rd   = im_rd[i];
      end
    end
  end

  // The last gap cycle arbitrates directly, so the slave sees exactly GAP_CYCLES idle cycles.
  assign w_gap_done  = (r_state == StGap) && (r_gap == GapLast);
  assign w_can_grant = (r_state == StIdle) || w_gap_done;
  assign w_hold_exp  = (r_hold == TIMEOUT - 64'd1);
  assign w_release   = (r_state == StBusy) && (!(w_m_wr || w_m_rd) || w_hold_exp);
  assign w_to        = (r_state == StBusy) && (w_m_wr || w_m_rd) && w_hold_exp;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) r_state <= StIdle;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_any) w_state_nxt = StBusy;
      StBusy: if (w_release) w_state_nxt = (GAP_CYCLES == 0) ? StIdle : StGap;
      StGap:  if (w_gap_done) w_state_nxt = w_any ? StBusy : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_cur_nxt     = r_cur;
    w_last_nxt    = r_last;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_wr_nxt      = r_wr;
    w_rd_nxt      = r_rd;
    w_rvalid_nxt  = '0;
    w_rdata_nxt   = r_rdata;
    w_timeout_nxt = 1'b0;
    w_mask_nxt    = r_mask & w_req;
    w_hold_nxt    = r_hold;
    w_gap_nxt     = r_gap;
    if (w_can_grant && w_any) begin
      w_gnt_nxt = '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) if (2'(i) == w_win) w_gnt_nxt[i] = 1'b1;
      w_cur_nxt  = w_win;
      w_last_nxt = w_win;
      w_addr_nxt = w_m_addr;
      w_data_nxt = w_m_data;
      w_wr_nxt   = w_m_wr;
      w_rd_nxt   = w_m_rd & ~w_m_wr;
      w_hold_nxt = '0;
    end else if (r_state == StBusy) begin
      if (w_release) begin
        w_gnt_nxt = '0;
        w_wr_nxt  = 1'b0;
        w_rd_nxt  = 1'b0;
        w_gap_nxt = '0;
        if (r_rd) begin
          w_rdata_nxt = w_to ? '1 : idata;
          for (int i = 0; i < int'(NUM_MASTERS); i++) if (2'(i) == r_cur) w_rvalid_nxt[i] = 1'b1;
        end
        if (w_to) begin
          w_timeout_nxt = 1'b1;
          for (int i = 0; i < int'(NUM_MASTERS); i++) if (2'(i) == r_cur) w_mask_nxt[i] = 1'b1;
        end
      end else begin
        w_addr_nxt = w_m_addr;
        w_data_nxt = w_m_data;
        w_wr_nxt   = w_m_wr;
        w_rd_nxt   = w_m_rd & ~w_m_wr;
        w_hold_nxt = r_hold + 64'd1;
      end
    end else if (r_state == StGap) begin
      w_gap_nxt = r_gap + 4'd1;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_gnt     <= '0;
      r_cur     <= '0;
      r_last    <= LastInit;
      r_addr    <= '0;
      r_data    <= '0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_rvalid  <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
      r_mask    <= '0;
      r_hold    <= '0;
      r_gap     <= '0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_cur     <= w_cur_nxt;
      r_last    <= w_last_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_wr      <= w_wr_nxt;
      r_rd      <= w_rd_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_timeout <= w_timeout_nxt;
      r_mask    <= w_mask_nxt;
      r_hold    <= w_hold_nxt;
      r_gap     <= w_gap_nxt;
    end
  end

  assign om_gnt    = r_gnt;
  assign om_rvalid = r_rvalid;
  assign om_rdata  = r_rdata;
  assign oaddr     = r_addr;
  assign odata     = r_data;
  assign owr       = r_wr;
  assign ord       = r_rd;
  assign otimeout  = r_timeout;
  assign ocur      = r_cur;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: vector table of single-master transactions plus
// hand sequences for arbitration order, gap, timeout and asynchronous reset.
module tb_cpu_bus_arbiter;

  localparam int N = 3;

  logic          iclk = 1'b0;
  logic          irst;
  logic [N*32-1:0] im_addr, im_data;
  logic [N-1:0]  im_wr, im_rd;
  logic [N-1:0]  om_gnt, om_rvalid;
  logic [31:0]   om_rdata, oaddr, odata, idata;
  logic          owr, ord, otimeout;
  logic [1:0]    ocur;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .GAP_CYCLES(1), .TIMEOUT(64'd8)
  ) dut (
    .iclk(iclk), .irst(irst), .im_addr(im_addr), .im_data(im_data), .im_wr(im_wr),
    .im_rd(im_rd), .om_gnt(om_gnt), .om_rvalid(om_rvalid), .om_rdata(om_rdata),
    .oaddr(oaddr), .odata(odata), .owr(owr), .ord(ord), .idata(idata),
    .otimeout(otimeout), .ocur(ocur)
  );

  always #5 iclk = ~iclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_m(input int m, input logic [31:0] a, input logic [31:0] d);
    im_addr[m*32 +: 32] = a;
    im_data[m*32 +: 32] = d;
  endtask

  task automatic do_reset();
    irst    = 1'b1;
    im_wr   = '0;
    im_rd   = '0;
    im_addr = '0;
    im_data = '0;
    idata   = '0;
    repeat (2) @(negedge iclk);
    irst = 1'b0;
    @(negedge iclk);
  endtask

  typedef struct packed {
    logic [1:0]  m;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  len;
    logic [31:0] sdata;
    logic [3:0]  exp_wr;
    logic [3:0]  exp_rd;
    logic        exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int gcnt = 0, wcnt = 0, rcnt = 0, rv = 0, other = 0, rv_it = -1, last_rd_it = -1;
    logic dropped = 1'b0;
    logic [31:0] rdat = '0;
    @(negedge iclk);
    set_m(int'(v.m), v.addr, v.data);
    im_wr[v.m] = v.wr;
    im_rd[v.m] = v.rd;
    idata      = v.sdata;
    for (int it = 0; it < 16; it++) begin
      @(negedge iclk);
      if (om_gnt[v.m]) begin
        gcnt++;
        if (gcnt == 1) begin
          check($sformatf("vec%0d addr", idx), 64'(oaddr), 64'(v.addr));
          check($sformatf("vec%0d data", idx), 64'(odata), 64'(v.data));
        end
      end
      if (owr) wcnt++;
      if (ord) begin rcnt++; last_rd_it = it; end
      if (om_rvalid[v.m]) begin rv++; rdat = om_rdata; rv_it = it; end
      if ((om_rvalid & ~(3'b001 << v.m)) != '0) other++;
      if (!dropped && gcnt == int'(v.len)) begin
        im_wr[v.m] = 1'b0;
        im_rd[v.m] = 1'b0;
        dropped    = 1'b1;
      end
    end
    check($sformatf("vec%0d gnt_cycles", idx), 64'(gcnt), 64'(v.len));
    check($sformatf("vec%0d owr_cycles", idx), 64'(wcnt), 64'(v.exp_wr));
    check($sformatf("vec%0d ord_cycles", idx), 64'(rcnt), 64'(v.exp_rd));
    check($sformatf("vec%0d rvalid_pulses", idx), 64'(rv), 64'(v.exp_rv));
    check($sformatf("vec%0d other_rvalid", idx), 64'(other), 64'd0);
    if (v.exp_rv) begin
      check($sformatf("vec%0d rdata", idx), 64'(rdat), 64'(v.exp_rdata));
      check($sformatf("vec%0d rvalid_timing", idx), 64'(rv_it), 64'(last_rd_it + 1));
    end
  endtask

  vec_t vecs [5];
  logic [2:0] exp_g [6];

  initial begin
    //            m     wr    rd    addr          data          len   sdata         ewr   erd   rv    rdata
    vecs[0] = {2'd0, 1'b0, 1'b1, 32'h10,       32'h0,        4'd3, 32'hA5,       4'd0, 4'd3, 1'b1, 32'hA5};
    vecs[1] = {2'd2, 1'b1, 1'b0, 32'h200,      32'hDEADBEEF, 4'd2, 32'h0,        4'd2, 4'd0, 1'b0, 32'h0};
    vecs[2] = {2'd1, 1'b1, 1'b1, 32'h300,      32'h1111,     4'd2, 32'h77,       4'd2, 4'd0, 1'b0, 32'h0};
    vecs[3] = {2'd1, 1'b0, 1'b1, 32'h400,      32'h0,        4'd1, 32'h12345678, 4'd0, 4'd1, 1'b1, 32'h12345678};
    vecs[4] = {2'd1, 1'b0, 1'b1, 32'h404,      32'h0,        4'd4, 32'h0F0F,     4'd0, 4'd4, 1'b1, 32'h0F0F};
    exp_g = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000};

    // Reset state
    do_reset();
    check("reset gnt", 64'(om_gnt), 64'd0);
    check("reset strobes", 64'({owr, ord, otimeout}), 64'd0);
    check("reset rvalid", 64'(om_rvalid), 64'd0);
    check("reset addr_data", {oaddr, odata}, 64'd0);
    check("reset rdata_cur", 64'({om_rdata, ocur}), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Simultaneous writes: master 0 first, one idle cycle, then master 1
    do_reset();
    begin
      int cnt [N];
      for (int i = 0; i < N; i++) cnt[i] = 0;
      set_m(0, 32'hA0, 32'hD0);
      set_m(1, 32'hA1, 32'hD1);
      im_wr = 3'b011;
      for (int it = 0; it < 6; it++) begin
        @(negedge iclk);
        check($sformatf("simul gnt it%0d", it), 64'(om_gnt), 64'(exp_g[it]));
        check($sformatf("simul owr it%0d", it), 64'(owr), 64'(exp_g[it] != 3'b000));
        if (exp_g[it] != 3'b000)
          check($sformatf("simul addr_data it%0d", it), {oaddr, odata},
                (it < 2) ? {32'hA0, 32'hD0} : {32'hA1, 32'hD1});
        for (int i = 0; i < N; i++) begin
          if (om_gnt[i]) begin
            cnt[i]++;
            if (cnt[i] == 2) im_wr[i] = 1'b0;
          end
        end
      end
    end

    // Timeout: master 1 holds a read for 20 cycles
    do_reset();
    begin
      int rcnt = 0, tcnt = 0, rv = 0, gcnt = 0;
      logic [31:0] rdat = '0;
      logic regrant = 1'b0;
      set_m(1, 32'h80, 32'h0);
      idata    = 32'h55;
      im_rd[1] = 1'b1;
      for (int it = 0; it < 20; it++) begin
        @(negedge iclk);
        if (ord) rcnt++;
        if (otimeout) tcnt++;
        if (om_gnt[1]) gcnt++;
        if (om_rvalid[1]) begin rv++; rdat = om_rdata; end
      end
      im_rd[1] = 1'b0;
      check("timeout ord_cycles", 64'(rcnt), 64'd8);
      check("timeout pulses", 64'(tcnt), 64'd1);
      check("timeout gnt_cycles", 64'(gcnt), 64'd8);
      check("timeout rvalid", 64'(rv), 64'd1);
      check("timeout rdata", 64'(rdat), 64'hFFFFFFFF);
      repeat (2) @(negedge iclk);
      im_rd[1] = 1'b1;
      for (int it = 0; it < 6 && !regrant; it++) begin
        @(negedge iclk);
        if (om_gnt[1]) regrant = 1'b1;
      end
      check("timeout regrant_after_drop", 64'(regrant), 64'd1);
      im_rd[1] = 1'b0;
      repeat (3) @(negedge iclk);
    end

    // Asynchronous reset during a busy read
    do_reset();
    begin
      logic got = 1'b0;
      logic [2:0] g = '0;
      set_m(1, 32'h44, 32'h0);
      im_rd[1] = 1'b1;
      repeat (2) @(negedge iclk);
      check("arst pre gnt", 64'(om_gnt), 64'b010);
      check("arst pre ord", 64'(ord), 64'd1);
      im_rd = 3'b111;
      #2;
      irst = 1'b1;
      #1;
      check("arst async clear", 64'({om_gnt, owr, ord, om_rvalid}), 64'd0);
      @(negedge iclk);
      irst     = 1'b0;
      im_rd[1] = 1'b0;
      for (int it = 0; it < 10 && !got; it++) begin
        @(negedge iclk);
        if (om_gnt != '0) begin got = 1'b1; g = om_gnt; end
      end
      check("arst next grant", 64'(g), 64'b001);
      im_rd = '0;
      repeat (4) @(negedge iclk);
    end

    // Round-robin fairness: three masters requesting continuously, 20 grants
    do_reset();
    begin
      int cnt [N];
      int ngr = 0;
      logic [2:0] prev_g = '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] = 0;
        set_m(i, 32'h1000 + 32'(i), 32'h2000 + 32'(i));
      end
      im_wr = 3'b111;
      for (int it = 0; it < 200 && ngr < 20; it++) begin
        @(negedge iclk);
        if (om_gnt != '0 && prev_g == '0) begin
          check($sformatf("rr grant %0d", ngr), 64'(om_gnt), 64'(3'b001 << (ngr % 3)));
          ngr++;
        end
        prev_g = om_gnt;
        for (int i = 0; i < N; i++) begin
          if (!im_wr[i]) im_wr[i] = 1'b1;
          else if (om_gnt[i]) begin
            cnt[i]++;
            if (cnt[i] == 2) begin im_wr[i] = 1'b0; cnt[i] = 0; end
          end
        end
      end
      check("rr grant_count", 64'(ngr), 64'd20);
      im_wr = '0;
      repeat (3) @(negedge iclk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Round-robin arbiter that shares one register bus slave among up to four simulation CPU bus masters. Each master drives the same level-strobe register bus the CPU masters use: address, write data, write strobe, read strobe and read data. The arbiter grants one master at a time and forwards its strobes to the slave with one registered cycle of latency. It returns captured read data with a per-master valid pulse and enforces a bus turnaround gap and a hold timeout.

## Interface

- NUM_MASTERS, 2, number of masters; legal range 2..4.
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width.
- GAP_CYCLES, 1, idle cycles forced on the slave bus between two grants; 0..15.
- TIMEOUT, 64'h100, maximum cycles one grant may last; must be ≥ 2.

Ports:

- iclk  in  1  single clock; all logic on its rising edge.
- irst  in  1  reset, asynchronous, active-high.
- im_addr  in  NUM_MASTERS*ADDR_WIDTH  master addresses; master i occupies slice i.
- im_data  in  NUM_MASTERS*DATA_WIDTH  master write data; master i occupies slice i.
- im_wr  in  NUM_MASTERS  per-master write strobe, level.
- im_rd  in  NUM_MASTERS  per-master read strobe, level.
- om_gnt  out  NUM_MASTERS  one-hot grant; all zero when no master is granted.
- om_rvalid  out  NUM_MASTERS  one-cycle pulse: om_rdata is valid for master i.
- om_rdata  out  DATA_WIDTH  captured read data, shared by all masters.
- oaddr  out  ADDR_WIDTH  slave address.
- odata  out  DATA_WIDTH  slave write data.
- owr  out  1  slave write strobe.
- ord  out  1  slave read strobe.
- idata  in  DATA_WIDTH  slave read data.
- otimeout  out  1  one-cycle pulse when a grant is force-terminated.
- ocur  out  2  index of the granted or last granted master.

## Operation

- Master i requests when req[i] = im_wr[i] | im_rd[i].
- If a master asserts both strobes, the access is a write: owr follows, ord stays 0.
- The FSM has three states: IDLE, BUSY and GAP.
- IDLE:
  - If any unmasked req is present, choose the first requester searching upward from (last+1) mod NUM_MASTERS, with wrap-around.
  - Register that choice into om_gnt, ocur and last; go to BUSY.
  - On the same edge, load oaddr/odata/owr/ord from the chosen master.
- BUSY, granted master still requesting:
  - oaddr/odata/owr/ord refresh from that master every cycle.
  - The hold counter increments.
- BUSY, granted master's req low:
  - owr and ord clear.
  - om_gnt clears.
  - If ord was 1, om_rdata <= idata and om_rvalid[ocur] pulses for one cycle.
  - Go to GAP, or to IDLE when GAP_CYCLES = 0.
- Timeout: if the hold counter reaches TIMEOUT while req is still high:
  - Terminate the grant exactly as a normal release.
  - On a read, the returned data is om_rdata = all ones; om_rvalid still pulses.
  - Pulse otimeout.
  - Set mask[ocur]. A masked master is ignored until its req drops, then the mask bit clears.
- GAP: hold all slave strobes low for GAP_CYCLES cycles, then go to IDLE. Requests arriving during GAP wait.
- A non-granted master sees om_gnt[i] = 0. Its strobes must stay asserted until granted; the slave strobe length equals the master's strobe cycles counted from the grant edge.
- oaddr and odata hold their last values while idle; they are not zeroed.

## Timing

- Reset values: all outputs are 0, with these state values:
  - last = NUM_MASTERS-1, so master 0 wins first.
  - The FSM is in IDLE.
  - mask = 0 and the counters are 0.
- Reset asserted mid-transaction clears the strobes, grant and pulses immediately (asynchronously).
- Latency: a request sampled at edge E0 in IDLE drives owr/ord high from E0.
- A master strobe last high before edge En gives a slave strobe falling at En. om_rvalid is high during cycle En..En+1, with om_rdata equal to idata sampled at En.
- Next grant occurs at edge En+GAP_CYCLES at the earliest. Slave strobes from different masters are therefore never adjacent when GAP_CYCLES ≥ 1.
- Round-robin with simultaneous requests: the winner is strictly the next index after last. A lone repeat requester is re-granted.
- Hold counter: 64-bit, cleared on every grant. Timeout fires on the edge where counter = TIMEOUT-1 with req still high, so a grant lasts at most TIMEOUT cycles.
- om_rvalid and otimeout are exactly one cycle wide and never assert in GAP or IDLE except on the release edge.

## Test plan

- Single master, read: NUM_MASTERS=2, master 0 holds im_rd 3 cycles at addr 0x10, slave returns 0xA5 → ord high 3 cycles from the grant edge; om_rvalid[0] pulses once the cycle after ord falls; om_rdata = 0xA5.
- Simultaneous requests: masters 0 and 1 both issue 2-cycle writes after reset → master 0 is served first; owr stays low 1 cycle (GAP_CYCLES=1); then master 1 is served with its own addr/data.
- Round-robin fairness: 3 masters requesting continuously for 20 grants → grant order 0,1,2,0,1,2…; no master skipped.
- Timeout: TIMEOUT=8, master 1 holds im_rd for 20 cycles → ord high 8 cycles; otimeout pulses; om_rvalid[1] with om_rdata = all ones. Master 1 is not re-granted until im_rd drops.
- Write-and-read conflict: a master asserts im_wr and im_rd together → owr = 1, ord = 0, no om_rvalid.
- Reset mid-operation: irst pulsed during a BUSY read → owr/ord/om_gnt go to 0 without waiting for the clock; the next grant goes to master 0.
